// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state encoding and frame-count defaults
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam int GRACE_FRAMES_DEF = 30;
    localparam int DEATH_FRAMES_DEF = 60;

endpackage

// File: rtl/game_controller_frame_counter.sv
// rtl/game_controller_frame_counter.sv - clearable frame-tick counter saturating at LIMIT
module frame_counter #(
    parameter int LIMIT      = 30,
    parameter bit EARLY_DONE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic tick_i,
    output logic done_o
);

    localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    logic [W-1:0] count_q;
    logic         at_limit;
    logic         hit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (tick_i && !at_limit) begin
            count_q <= count_q + W'(1);
        end
    end

    assign at_limit = (count_q == LIMIT[W-1:0]);
    // EARLY_DONE flags the tick that reaches LIMIT instead of the state after it
    assign hit      = tick_i && (({1'b0, count_q} + (W+1)'(1)) == LIMIT[W:0]);
    assign done_o   = EARLY_DONE ? hit : at_limit;

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - game FSM, scoring and optional high score (HIGH_SCORE_EN)
module game_controller
    import game_pkg::*;
#(
    parameter int SCORE_W      = 8,
    parameter int GRACE_FRAMES = GRACE_FRAMES_DEF,
    parameter int DEATH_FRAMES = DEATH_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               flap,
    input  logic               collision,
    input  logic               passed,
    output logic [1:0]         state,
    output logic               run_en,
    output logic               world_reset,
    output logic               flap_out,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    game_state_t        state_q, state_d;
    logic               run_en_q, run_en_d;
    logic               world_reset_q, world_reset_d;
    logic               flap_out_q, flap_out_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic start, die, grace_done, death_done;

    assign start = (state_q == IDLE) && flap;
    assign die   = (state_q == PLAY) && frame_tick && grace_done && collision;

    frame_counter #(.LIMIT(GRACE_FRAMES), .EARLY_DONE(1'b0)) u_grace (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (start),
        .tick_i  ((state_q == PLAY) && frame_tick),
        .done_o  (grace_done)
    );

    frame_counter #(.LIMIT(DEATH_FRAMES), .EARLY_DONE(1'b1)) u_death (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (die),
        .tick_i  ((state_q == DYING) && frame_tick),
        .done_o  (death_done)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            run_en_q      <= 1'b0;
            world_reset_q <= 1'b1;
            flap_out_q    <= 1'b0;
            score_q       <= '0;
        end else begin
            state_q       <= state_d;
            run_en_q      <= run_en_d;
            world_reset_q <= world_reset_d;
            flap_out_q    <= flap_out_d;
            score_q       <= score_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (flap)       state_d = PLAY;
            PLAY:  if (die)        state_d = DYING;
            DYING: if (death_done) state_d = OVER;
            OVER:  if (flap)       state_d = IDLE;
        endcase
    end

    always_comb begin
        run_en_d      = (state_d == PLAY);
        flap_out_d    = flap && ((state_q == IDLE) || (state_q == PLAY));
        world_reset_d = (state_q == OVER) && flap;
        score_d       = score_q;
        if (start) begin
            score_d = '0;
        end else if ((state_q == PLAY) && passed && !die && (score_q != '1)) begin
            score_d = score_q + SCORE_W'(1);
        end
    end

    assign state       = state_q;
    assign run_en      = run_en_q;
    assign world_reset = world_reset_q;
    assign flap_out    = flap_out_q;
    assign score       = score_q;

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            high_score_q <= '0;
        end else if (die && (score_q > high_score_q)) begin
            high_score_q <= score_q;
        end
    end

    assign high_score = high_score_q;
`else
    assign high_score = '0;
`endif

endmodule
